// File: rtl/ev_motor_pkg.sv
// Shared types, default constants and helpers for the multi-channel EV motor drive.
package ev_motor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2,
        HOLD    = 2'd3
    } ch_state_e;

    localparam int TEMP_AMB_DEF   = 25;
    localparam int TEMP_TRIP_DEF  = 85;
    localparam int TEMP_CLEAR_DEF = 75;
    localparam int TEMP_MAX_DEF   = 100;
    localparam int HOT_SPD_DEF    = 50;

    // Net pedal demand scaled up to duty width; brake at or above accel means stop.
    function automatic int unsigned scale_target(input int unsigned accel,
                                                 input int unsigned brake,
                                                 input int unsigned shift);
        return (accel > brake) ? ((accel - brake) << shift) : 32'd0;
    endfunction

endpackage

// File: rtl/ev_motor_drive_multi_channel.sv
// One motor channel: held target, slew-limited speed FSM and registered PWM compare.
module ev_ramp_channel
    import ev_motor_pkg::*;
#(
    parameter int DUTY_W    = 8,
    parameter int CMD_W     = 4,
    parameter int RAMP_STEP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              estop,
    input  logic              tick,
    input  logic              overheat,
    input  logic              cmd_we,
    input  logic [CMD_W-1:0]  cmd_accel,
    input  logic [CMD_W-1:0]  cmd_brake,
    input  logic [DUTY_W-1:0] pwm_cnt,
    output logic [DUTY_W-1:0] speed_o,
    output logic              busy_o,
    output logic              pwm_o
);

    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);

    ch_state_e         state_q, state_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [DUTY_W-1:0] speed_q, speed_d;
    logic [DUTY_W-1:0] eff, diff;
    logic              pwm_q, pwm_d;

    always_comb begin
        target_d = target_q;
        speed_d  = speed_q;
        state_d  = state_q;
        diff     = '0;
        eff      = overheat ? (target_q >> 1) : target_q;
        pwm_d    = (pwm_cnt < speed_q);

        if (estop) begin
            target_d = '0;
            speed_d  = '0;
            state_d  = IDLE;
        end else begin
            // The tick works on target_q, so a command landing on the same edge waits a tick.
            if (tick) begin
                if (speed_q < eff) begin
                    diff    = eff - speed_q;
                    speed_d = speed_q + ((diff > STEP) ? STEP : diff);
                    state_d = RAMP_UP;
                end else if (speed_q > eff) begin
                    diff    = speed_q - eff;
                    speed_d = speed_q - ((diff > STEP) ? STEP : diff);
                    state_d = RAMP_DN;
                end else begin
                    state_d = (speed_q == '0) ? IDLE : HOLD;
                end
            end
            if (cmd_we) begin
                target_d = DUTY_W'(scale_target(32'(cmd_accel), 32'(cmd_brake),
                                                32'(DUTY_W - CMD_W)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            speed_q  <= '0;
            pwm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            speed_q  <= speed_d;
            pwm_q    <= pwm_d;
        end
    end

    assign speed_o = speed_q;
    assign busy_o  = (state_q != IDLE);
    assign pwm_o   = pwm_q;

endmodule

// File: rtl/ev_motor_drive_multi.sv
// Multi-channel EV motor drive: command decode, prescaler, shared PWM counter, thermal derating.
// Define EV_PWM_CENTER_ALIGNED_EN for an up/down (center-aligned) PWM counter.
module ev_motor_drive_multi
    import ev_motor_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DUTY_W     = 8,
    parameter int CMD_W      = 4,
    parameter int RAMP_STEP  = 16,
    parameter int TICK_DIV   = 1024,
    parameter int TEMP_W     = 7,
    parameter int TEMP_AMB   = TEMP_AMB_DEF,
    parameter int TEMP_TRIP  = TEMP_TRIP_DEF,
    parameter int TEMP_CLEAR = TEMP_CLEAR_DEF,
    parameter int TEMP_MAX   = TEMP_MAX_DEF,
    parameter int HOT_SPD    = HOT_SPD_DEF,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     estop,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CH_W-1:0]          cmd_ch,
    input  logic [CMD_W-1:0]         cmd_accel,
    input  logic [CMD_W-1:0]         cmd_brake,
    output logic [NUM_CH-1:0]        pwm_out,
    output logic [NUM_CH*DUTY_W-1:0] speed_o,
    output logic [NUM_CH-1:0]        busy_o,
    output logic [TEMP_W-1:0]        temp_o,
    output logic                     overheat_o
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int CHW1  = CH_W + 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [CH_W:0]     NUM_CH_L = CHW1'(NUM_CH);
    localparam logic [DUTY_W-1:0] HOT_L    = DUTY_W'(HOT_SPD);
    localparam logic [DUTY_W-1:0] CNT_MAX  = '1;
    localparam logic [TEMP_W-1:0] T_AMB    = TEMP_W'(TEMP_AMB);
    localparam logic [TEMP_W-1:0] T_TRIP   = TEMP_W'(TEMP_TRIP);
    localparam logic [TEMP_W-1:0] T_CLR    = TEMP_W'(TEMP_CLEAR);
    localparam logic [TEMP_W-1:0] T_MAX    = TEMP_W'(TEMP_MAX);

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [TEMP_W-1:0] temp_q, temp_d;
    logic              overheat_q, overheat_d;
    logic              rdy_q;
    logic              tick, accept, ch_ok;
    logic [NUM_CH-1:0] hot_w, we_w;
`ifdef EV_PWM_CENTER_ALIGNED_EN
    logic              cnt_dn_q, cnt_dn_d;
`endif

    // Ready drops combinationally with estop so no command slips in on the estop cycle.
    assign cmd_ready = rdy_q & ~estop;
    assign accept    = cmd_valid & cmd_ready;
    assign ch_ok     = ({1'b0, cmd_ch} < NUM_CH_L);
    assign tick      = (presc_q == PRE_MAX);

    always_comb begin
        presc_d    = tick ? '0 : presc_q + 1'b1;
        temp_d     = temp_q;
        overheat_d = overheat_q;

`ifdef EV_PWM_CENTER_ALIGNED_EN
        cnt_dn_d = cnt_dn_q;
        if (!cnt_dn_q) begin
            if (pwm_cnt_q == CNT_MAX) begin
                cnt_dn_d  = 1'b1;
                pwm_cnt_d = pwm_cnt_q - 1'b1;
            end else begin
                pwm_cnt_d = pwm_cnt_q + 1'b1;
            end
        end else begin
            if (pwm_cnt_q == '0) begin
                cnt_dn_d  = 1'b0;
                pwm_cnt_d = pwm_cnt_q + 1'b1;
            end else begin
                pwm_cnt_d = pwm_cnt_q - 1'b1;
            end
        end
`else
        pwm_cnt_d = pwm_cnt_q + 1'b1;
`endif

        if (tick) begin
            if (|hot_w) begin
                temp_d = (temp_q >= T_MAX) ? T_MAX : temp_q + 1'b1;
            end else begin
                temp_d = (temp_q <= T_AMB) ? T_AMB : temp_q - 1'b1;
            end
        end

        // Hysteresis band between clear and trip keeps the previous state.
        if (temp_q >= T_TRIP) begin
            overheat_d = 1'b1;
        end else if (temp_q <= T_CLR) begin
            overheat_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            temp_q     <= T_AMB;
            overheat_q <= 1'b0;
            rdy_q      <= 1'b0;
`ifdef EV_PWM_CENTER_ALIGNED_EN
            cnt_dn_q   <= 1'b0;
`endif
        end else begin
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            temp_q     <= temp_d;
            overheat_q <= overheat_d;
            rdy_q      <= 1'b1;
`ifdef EV_PWM_CENTER_ALIGNED_EN
            cnt_dn_q   <= cnt_dn_d;
`endif
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign we_w[gi]  = accept & ch_ok & (cmd_ch == CH_W'(gi));
        assign hot_w[gi] = (speed_o[gi*DUTY_W +: DUTY_W] > HOT_L);

        ev_ramp_channel #(
            .DUTY_W    (DUTY_W),
            .CMD_W     (CMD_W),
            .RAMP_STEP (RAMP_STEP)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .estop     (estop),
            .tick      (tick),
            .overheat  (overheat_q),
            .cmd_we    (we_w[gi]),
            .cmd_accel (cmd_accel),
            .cmd_brake (cmd_brake),
            .pwm_cnt   (pwm_cnt_q),
            .speed_o   (speed_o[gi*DUTY_W +: DUTY_W]),
            .busy_o    (busy_o[gi]),
            .pwm_o     (pwm_out[gi])
        );
    end

    assign temp_o     = temp_q;
    assign overheat_o = overheat_q;

endmodule

// File: tb/tb_ev_motor_drive_multi.sv
// Self-checking bench: command table with a per-channel speed scoreboard plus hand sequences.
`timescale 1ns/1ps
module tb_ev_motor_drive_multi;

    logic        clk = 1'b0;
    logic        rst, estop;
    logic        cmd_valid, cmd_ready;
    logic [0:0]  cmd_ch;
    logic [3:0]  cmd_accel, cmd_brake;
    logic [1:0]  pwm_out, busy_o;
    logic [15:0] speed_o;
    logic [6:0]  temp_o;
    logic        overheat_o;

    logic        cmd_valid1, cmd_ready1;
    logic [0:0]  cmd_ch1;
    logic [3:0]  cmd_accel1, cmd_brake1;
    logic [0:0]  pwm_out1, busy1_o;
    logic [7:0]  speed1_o;
    logic [6:0]  temp1_o;
    logic        overheat1_o;

    always #5 clk = ~clk;

    ev_motor_drive_multi #(.NUM_CH(2), .RAMP_STEP(16), .TICK_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .estop(estop),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
        .cmd_accel(cmd_accel), .cmd_brake(cmd_brake),
        .pwm_out(pwm_out), .speed_o(speed_o), .busy_o(busy_o),
        .temp_o(temp_o), .overheat_o(overheat_o)
    );

    ev_motor_drive_multi #(.NUM_CH(1), .RAMP_STEP(16), .TICK_DIV(4)) u_dut1 (
        .clk(clk), .rst(rst), .estop(estop),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ch(cmd_ch1),
        .cmd_accel(cmd_accel1), .cmd_brake(cmd_brake1),
        .pwm_out(pwm_out1), .speed_o(speed1_o), .busy_o(busy1_o),
        .temp_o(temp1_o), .overheat_o(overheat1_o)
    );

    typedef struct {
        int ch;
        int accel;
        int brake;
        int exp_tgt;
        int pwm_exp;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   exp0[$];
    int   exp1[$];
    int   model_spd[2];
    int   last0, last1;
    int   cyc;
    logic mon_en;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_val(input int ch, input int v);
        if (ch == 0) exp0.push_back(v);
        else         exp1.push_back(v);
        model_spd[ch] = v;
    endtask

    // Reference slew: at most 16 per tick toward the target, never past it.
    task automatic push_traj(input int ch, input int tgt);
        int cur = model_spd[ch];
        while (cur != tgt) begin
            if (cur < tgt) cur += ((tgt - cur) > 16) ? 16 : (tgt - cur);
            else           cur -= ((cur - tgt) > 16) ? 16 : (cur - tgt);
            push_val(ch, cur);
        end
    endtask

    task automatic sb_pop(input int ch, input int act, input int prev);
        int exp;
        $display("ch%0d speed=%0d cyc=%0d", ch, act, cyc);
        if ((ch == 0 && exp0.size() == 0) || (ch == 1 && exp1.size() == 0)) begin
            check($sformatf("unexpected_change_ch%0d", ch), act, prev);
        end else begin
            exp = (ch == 0) ? exp0.pop_front() : exp1.pop_front();
            check($sformatf("ramp_ch%0d", ch), act, exp);
            if (!estop) check($sformatf("tick_phase_ch%0d", ch), cyc % 4, 0);
        end
    endtask

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (int'(speed_o[7:0]) != last0)  sb_pop(0, int'(speed_o[7:0]), last0);
            if (int'(speed_o[15:8]) != last1) sb_pop(1, int'(speed_o[15:8]), last1);
        end
        last0 <= int'(speed_o[7:0]);
        last1 <= int'(speed_o[15:8]);
    end

    task automatic send_cmd(input int ch, input int a, input int b);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ch    = 1'(ch);
        cmd_accel = 4'(a);
        cmd_brake = 4'(b);
        $display("cmd ch=%0d accel=%0d brake=%0d", ch, a, b);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int ok = 0;
        for (int i = 0; i < 400 && ok == 0; i++) begin
            @(negedge clk);
            if (exp0.size() == 0 && exp1.size() == 0) ok = 1;
        end
        check(name, ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        int   ok, n0, n1;

        vecs[0] = '{ch: 1, accel: 5, brake: 2, exp_tgt: 48, pwm_exp: 48};
        vecs[1] = '{ch: 1, accel: 3, brake: 9, exp_tgt: 0,  pwm_exp: -1};
        vecs[2] = '{ch: 0, accel: 9, brake: 3, exp_tgt: 96, pwm_exp: -1};

        rst = 1'b1; estop = 1'b0; mon_en = 1'b0;
        cmd_valid = 1'b0; cmd_ch = '0; cmd_accel = '0; cmd_brake = '0;
        cmd_valid1 = 1'b0; cmd_ch1 = '0; cmd_accel1 = '0; cmd_brake1 = '0;
        model_spd[0] = 0; model_spd[1] = 0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_speed", int'(speed_o), 0);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_temp", int'(temp_o), 25);
        check("rst_overheat", int'(overheat_o), 0);
        check("rst_ready", int'(cmd_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(cmd_ready), 1);
        check("ready1_after_rst", int'(cmd_ready1), 1);
        mon_en = 1'b1;

        // Single-channel build: out-of-range channel is accepted and dropped
        cmd_valid1 = 1'b1; cmd_ch1 = 1'b1; cmd_accel1 = 4'd15; cmd_brake1 = 4'd0;
        $display("cmd dut1 ch=1 accel=15 brake=0");
        @(negedge clk);
        check("dut1_ready_invalid_ch", int'(cmd_ready1), 1);
        cmd_valid1 = 1'b0;
        repeat (16) @(negedge clk);
        check("dut1_invalid_speed", int'(speed1_o), 0);
        check("dut1_invalid_busy", int'(busy1_o), 0);
        cmd_valid1 = 1'b1; cmd_ch1 = 1'b0; cmd_accel1 = 4'd2; cmd_brake1 = 4'd0;
        $display("cmd dut1 ch=0 accel=2 brake=0");
        @(negedge clk);
        cmd_valid1 = 1'b0;
        repeat (16) @(negedge clk);
        check("dut1_valid_speed", int'(speed1_o), 32);

        // Table-driven commands
        for (int v = 0; v < 3; v++) begin
            push_traj(vecs[v].ch, vecs[v].exp_tgt);
            send_cmd(vecs[v].ch, vecs[v].accel, vecs[v].brake);
            drain($sformatf("drain_vec%0d", v));
            repeat (10) @(negedge clk);
            check($sformatf("vec%0d_speed", v),
                  (vecs[v].ch == 0) ? int'(speed_o[7:0]) : int'(speed_o[15:8]), vecs[v].exp_tgt);
            check($sformatf("vec%0d_busy", v), int'(busy_o[vecs[v].ch]),
                  (vecs[v].exp_tgt != 0) ? 1 : 0);
            if (vecs[v].pwm_exp >= 0) begin
                n0 = 0; n1 = 0;
                repeat (256) begin
                    @(negedge clk);
                    n0 += int'(pwm_out[0]);
                    n1 += int'(pwm_out[1]);
                end
                check($sformatf("vec%0d_pwm_duty", v), (vecs[v].ch == 0) ? n0 : n1, vecs[v].pwm_exp);
                check($sformatf("vec%0d_pwm_other", v), (vecs[v].ch == 0) ? n1 : n0,
                      model_spd[1 - vecs[v].ch]);
            end
        end
        check("ch1_idle_during_ch0", int'(busy_o[1]), 0);

        // Back-to-back commands to one channel: the second one wins
        push_traj(1, 16);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ch = 1'b1; cmd_accel = 4'd2; cmd_brake = 4'd0;
        $display("cmd ch=1 accel=2 brake=0");
        @(negedge clk);
        cmd_accel = 4'd1;
        $display("cmd ch=1 accel=1 brake=0");
        @(negedge clk);
        cmd_valid = 1'b0;
        drain("drain_b2b");
        repeat (10) @(negedge clk);
        check("b2b_speed", int'(speed_o[15:8]), 16);

        // estop mid-ramp at speed 48
        push_val(0, 80); push_val(0, 64); push_val(0, 48);
        send_cmd(0, 0, 0);
        ok = 0;
        for (int i = 0; i < 100 && ok == 0; i++) begin
            @(negedge clk);
            if (speed_o[7:0] == 8'd48) ok = 1;
        end
        check("estop_reach_48", ok, 1);
        estop = 1'b1;
        $display("estop asserted");
        push_val(0, 0); push_val(1, 0);
        @(negedge clk);
        check("estop_speed", int'(speed_o), 0);
        check("estop_ready", int'(cmd_ready), 0);
        @(negedge clk);
        check("estop_pwm", int'(pwm_out), 0);
        cmd_valid = 1'b1; cmd_ch = 1'b0; cmd_accel = 4'd15; cmd_brake = 4'd0;
        $display("cmd during estop ch=0 accel=15 brake=0");
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        estop = 1'b0;
        $display("estop released");
        #1;
        check("ready_after_estop", int'(cmd_ready), 1);
        repeat (20) @(negedge clk);
        check("post_estop_speed", int'(speed_o), 0);
        check("post_estop_busy", int'(busy_o), 0);
        check("sb_empty", exp0.size() + exp1.size(), 0);

        // Thermal derating with hysteresis
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("thermal_rst_temp", int'(temp_o), 25);
        send_cmd(0, 15, 0);
        ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            @(negedge clk);
            if (speed_o[7:0] == 8'd240) ok = 1;
        end
        check("reach_240", ok, 1);
        check("no_overheat_at_240", int'(overheat_o), 0);
        ok = 0;
        for (int i = 0; i < 600 && ok == 0; i++) begin
            @(negedge clk);
            if (overheat_o) ok = 1;
        end
        check("overheat_rise_seen", ok, 1);
        check("overheat_rise_temp", int'(temp_o), 85);
        ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            @(negedge clk);
            if (speed_o[7:0] == 8'd120) ok = 1;
        end
        check("derated_120", ok, 1);
        repeat (100) @(negedge clk);
        check("temp_saturate", int'(temp_o), 100);
        check("derated_hold", int'(speed_o[7:0]), 120);
        send_cmd(0, 0, 0);
        ok = 0;
        for (int i = 0; i < 600 && ok == 0; i++) begin
            @(negedge clk);
            if (!overheat_o) ok = 1;
        end
        check("overheat_fall_seen", ok, 1);
        check("overheat_fall_temp", int'(temp_o), 75);
        repeat (300) @(negedge clk);
        check("temp_floor", int'(temp_o), 25);

        // Reset mid-ramp clears speed and target
        send_cmd(0, 15, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midramp_rst_speed", int'(speed_o), 0);
        check("midramp_rst_busy", int'(busy_o), 0);
        repeat (16) @(negedge clk);
        check("midramp_rst_target", int'(speed_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
